// File: rtl/uart_pkg.sv
// Shared constants, types and the configuration check for the UART baud generator.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_BAUD = 9600;
  localparam int unsigned UART_DEFAULT_FREQ = 100_000_000;
  localparam int unsigned UART_OVERSAMPLE   = 16;
  localparam int unsigned UART_BAUD_W       = 20;
  localparam int unsigned UART_FREQ_W       = 30;
  localparam int unsigned UART_CFG_CALC_W   = 64;

  typedef enum logic [1:0] {
    APPLY_NONE,
    APPLY_ACK,
    APPLY_ERR
  } apply_e;

  // The oversample rate must fit at least twice into the clock so that ticks never merge.
  function automatic logic baud_cfg_valid(
    input logic [UART_CFG_CALC_W-1:0] baud,
    input logic [UART_CFG_CALC_W-1:0] freq,
    input int unsigned                os
  );
    logic [UART_CFG_CALC_W-1:0] need;
    need = (baud * UART_CFG_CALC_W'(os)) << 1;
    return (baud != '0) && (freq != '0) && (need <= freq);
  endfunction

endpackage

// File: rtl/frac_tick_nco.sv
// Phase accumulator with modulus wrap; emits a registered tick on every overflow.
module frac_tick_nco #(
  parameter int unsigned STEP_W = 22,
  parameter int unsigned ACC_W  = 31
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [ACC_W-1:0]  modulus_i,
  output logic              overflow_o,
  output logic              tick_o
);

  localparam int unsigned MAX_W = (STEP_W > ACC_W) ? STEP_W : ACC_W;
  localparam int unsigned SUM_W = MAX_W + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;
  logic [SUM_W-1:0] sum, modExt;
  logic             over;

  // Overflow ignores clear so a tick landing on a restart edge is still emitted.
  always_comb begin
    sum    = SUM_W'(acc_q) + SUM_W'(step_i);
    modExt = SUM_W'(modulus_i);
    over   = en_i && (sum >= modExt);
    acc_d  = ACC_W'(sum);
    if (!en_i || clear_i) begin
      acc_d = '0;
    end else if (over) begin
      acc_d = ACC_W'(sum - modExt);
    end
    tick_d = over;
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign overflow_o = over;
  assign tick_o     = tick_q;

endmodule

// File: rtl/uart_baud_nco.sv
// Fractional baud-rate generator: NCO-derived oversample/bit ticks and uartClock,
// with a shadow configuration that only switches on a bit boundary or while idle.
module uart_baud_nco
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE   = UART_OVERSAMPLE,
  parameter int unsigned BAUD_W       = UART_BAUD_W,
  parameter int unsigned FREQ_W       = UART_FREQ_W,
  parameter int unsigned DEFAULT_BAUD = UART_DEFAULT_BAUD,
  parameter int unsigned DEFAULT_FREQ = UART_DEFAULT_FREQ
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              enable,
  input  logic [BAUD_W-1:0] BaudRate,
  input  logic [FREQ_W-1:0] ClockFrequency,
  input  logic              cfg_load,
  output logic              cfg_ack,
  output logic              cfg_error,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              uartClock
);

  localparam int unsigned OS_LOG2 = $clog2(OVERSAMPLE);
  localparam int unsigned STEP_W  = BAUD_W + OS_LOG2;
  localparam int unsigned ACC_W   = FREQ_W + 1;
  localparam logic [OS_LOG2-1:0] OS_LAST = OS_LOG2'(OVERSAMPLE - 1);
  localparam logic [OS_LOG2-1:0] OS_HALF = OS_LOG2'(OVERSAMPLE / 2);

  logic [BAUD_W-1:0]  baudAct_q, baudPend_q;
  logic [FREQ_W-1:0]  freqAct_q, freqPend_q;
  logic               pend_q, pend_d;
  logic               ticked_q, ticked_d;
  logic [OS_LOG2-1:0] osCnt_q, osCnt_d;
  logic               bitTick_q, uartClk_q, uartClk_d;
  logic               cfgAck_q, cfgErr_q;

  logic [STEP_W-1:0]  step;
  logic [ACC_W-1:0]   modulus;
  logic               overflow, osTick, wrap, applyPoint, clearPhase, cfgValid;
  apply_e             applyRes;

  assign step     = {baudAct_q, {OS_LOG2{1'b0}}};
  assign modulus  = {1'b0, freqAct_q};
  assign cfgValid = baud_cfg_valid(UART_CFG_CALC_W'(baudPend_q),
                                   UART_CFG_CALC_W'(freqPend_q), OVERSAMPLE);

  frac_tick_nco #(
    .STEP_W (STEP_W),
    .ACC_W  (ACC_W)
  ) u_nco (
    .clock      (clock),
    .Reset      (Reset),
    .en_i       (enable),
    .clear_i    (clearPhase),
    .step_i     (step),
    .modulus_i  (modulus),
    .overflow_o (overflow),
    .tick_o     (osTick)
  );

  // Before the first overflow since enable nothing has been emitted, so a switch is harmless.
  always_comb begin
    wrap       = overflow && (osCnt_q == OS_LAST);
    applyPoint = wrap || !enable || (!ticked_q && !overflow);
    applyRes   = APPLY_NONE;
    if (pend_q && applyPoint) begin
      applyRes = cfgValid ? APPLY_ACK : APPLY_ERR;
    end
    clearPhase = (applyRes == APPLY_ACK);

    osCnt_d = osCnt_q;
    if (!enable || clearPhase) begin
      osCnt_d = '0;
    end else if (overflow) begin
      osCnt_d = osCnt_q + OS_LOG2'(1);
    end
    uartClk_d = (osCnt_d < OS_HALF);

    ticked_d = enable && (ticked_q || overflow);
    pend_d   = cfg_load || (pend_q && (applyRes == APPLY_NONE));
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      baudAct_q  <= BAUD_W'(DEFAULT_BAUD);
      freqAct_q  <= FREQ_W'(DEFAULT_FREQ);
      baudPend_q <= '0;
      freqPend_q <= '0;
      pend_q     <= 1'b0;
      ticked_q   <= 1'b0;
      osCnt_q    <= '0;
      bitTick_q  <= 1'b0;
      uartClk_q  <= 1'b1;
      cfgAck_q   <= 1'b0;
      cfgErr_q   <= 1'b0;
    end else begin
      if (cfg_load) begin
        baudPend_q <= BaudRate;
        freqPend_q <= ClockFrequency;
      end
      if (applyRes == APPLY_ACK) begin
        baudAct_q <= baudPend_q;
        freqAct_q <= freqPend_q;
      end
      pend_q    <= pend_d;
      ticked_q  <= ticked_d;
      osCnt_q   <= osCnt_d;
      bitTick_q <= wrap;
      uartClk_q <= uartClk_d;
      cfgAck_q  <= (applyRes == APPLY_ACK);
      cfgErr_q  <= (applyRes == APPLY_ERR);
    end
  end

  assign cfg_ack   = cfgAck_q;
  assign cfg_error = cfgErr_q;
  assign os_tick   = osTick;
  assign bit_tick  = bitTick_q;
  assign uartClock = uartClk_q;

endmodule

// File: tb/tb_uart_baud_nco.sv
// Directed bench for uart_baud_nco at OVERSAMPLE=4: config path table, then live-rate sequences.
module tb_uart_baud_nco;

  localparam int OS = 4;
  localparam int BW = 20;
  localparam int FW = 30;
  localparam int DEF_FIRST_OS = 2605; // ceil(100_000_000 / (9600*4))

  logic          clock = 1'b0;
  logic          Reset, enable, cfg_load;
  logic [BW-1:0] BaudRate;
  logic [FW-1:0] ClockFrequency;
  logic          cfg_ack, cfg_error, os_tick, bit_tick, uartClock;

  int compared = 0;
  int mismatched = 0;

  int n, base, stepM, freqM, expAckAt, expErrAt, switchAt, newStep;
  int osCount, bitCount, lastOs, minSp, maxSp;

  typedef struct {
    logic       rst;
    logic       load;
    int         baud;
    int         freq;
    logic [4:0] exp; // {ack, err, os, bit, uclk}
  } vec_t;

  vec_t vecs[20];

  always #5 clock = ~clock;

  uart_baud_nco #(
    .OVERSAMPLE (OS),
    .BAUD_W     (BW),
    .FREQ_W     (FW)
  ) dut (
    .clock          (clock),
    .Reset          (Reset),
    .enable         (enable),
    .BaudRate       (BaudRate),
    .ClockFrequency (ClockFrequency),
    .cfg_load       (cfg_load),
    .cfg_ack        (cfg_ack),
    .cfg_error      (cfg_error),
    .os_tick        (os_tick),
    .bit_tick       (bit_tick),
    .uartClock      (uartClock)
  );

  function automatic vec_t mk(input logic r, input logic l, input int b, input int f,
                              input logic [4:0] e);
    vec_t v;
    v.rst  = r;
    v.load = l;
    v.baud = b;
    v.freq = f;
    v.exp  = e;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {cfg_ack, cfg_error, os_tick, bit_tick, uartClock};
  endfunction

  task automatic applyStimulus(input logic rst, input logic en, input logic load,
                               input int baud, input int freq);
    Reset          = rst;
    enable         = en;
    cfg_load       = load;
    BaudRate       = BW'(baud);
    ClockFrequency = FW'(freq);
  endtask

  task automatic stepClk();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Closed-form expectation: after m edges from a restart, cnt = floor(m*step/freq) oversample ticks.
  task automatic runTo(input int nEnd);
    int m, cnt, prv, sp;
    logic [4:0] exp;
    while (n < nEnd) begin
      stepClk();
      n++;
      m   = n - base;
      cnt = (m * stepM) / freqM;
      prv = ((m - 1) * stepM) / freqM;
      exp[2] = (cnt != prv);
      exp[1] = exp[2] && (cnt % OS == 0);
      exp[0] = (cnt % OS) < (OS / 2);
      exp[4] = (n == expAckAt);
      exp[3] = (n == expErrAt);
      checkOutput($sformatf("run n=%0d", n), 32'(outs()), 32'(exp));
      if (os_tick) begin
        osCount++;
        if (lastOs >= 0) begin
          sp = n - lastOs;
          if (sp < minSp) minSp = sp;
          if (sp > maxSp) maxSp = sp;
        end
        lastOs = n;
      end
      if (bit_tick) bitCount++;
      if (n == switchAt) begin
        base  = n;
        stepM = newStep;
      end
    end
  endtask

  task automatic loadRun(input int baud, input int freq);
    applyStimulus(1'b0, 1'b1, 1'b1, baud, freq);
    runTo(n + 1);
    cfg_load = 1'b0;
  endtask

  initial begin
    int firstOs;
    logic sawCfg;

    vecs[0]  = mk(1, 0, 0,   0,   5'b00001);
    vecs[1]  = mk(1, 0, 0,   0,   5'b00001);
    vecs[2]  = mk(0, 1, 1,   100, 5'b00001);
    vecs[3]  = mk(0, 0, 0,   0,   5'b10001);
    vecs[4]  = mk(0, 0, 0,   0,   5'b00001);
    vecs[5]  = mk(0, 1, 13,  100, 5'b00001);
    vecs[6]  = mk(0, 0, 0,   0,   5'b01001);
    vecs[7]  = mk(0, 0, 0,   0,   5'b00001);
    vecs[8]  = mk(0, 1, 0,   100, 5'b00001);
    vecs[9]  = mk(0, 0, 0,   0,   5'b01001);
    vecs[10] = mk(0, 1, 1,   0,   5'b00001);
    vecs[11] = mk(0, 1, 12,  100, 5'b01001);
    vecs[12] = mk(0, 0, 0,   0,   5'b10001);
    vecs[13] = mk(0, 1, 25,  200, 5'b00001);
    vecs[14] = mk(0, 0, 0,   0,   5'b10001);
    vecs[15] = mk(0, 1, 26,  200, 5'b00001);
    vecs[16] = mk(0, 0, 0,   0,   5'b01001);
    vecs[17] = mk(0, 1, 1,   100, 5'b00001);
    vecs[18] = mk(0, 0, 0,   0,   5'b10001);
    vecs[19] = mk(0, 0, 0,   0,   5'b00001);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, 1'b0, vecs[i].load, vecs[i].baud, vecs[i].freq);
      stepClk();
      checkOutput($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Live run at baud=1/freq=100, then switches on bit boundaries.
    n = 0; base = 0; stepM = 4; freqM = 100;
    expAckAt = -1; expErrAt = -1; switchAt = -1; newStep = 4;
    osCount = 0; bitCount = 0; lastOs = -1; minSp = 1000; maxSp = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    runTo(140);
    expAckAt = 200; switchAt = 200; newStep = 8;
    loadRun(2, 100);
    runTo(305);
    expAckAt = 350; switchAt = 350; newStep = 16;
    loadRun(2, 100);
    runTo(320);
    loadRun(4, 100);
    runTo(380);
    expErrAt = 400;
    loadRun(13, 100);
    runTo(460);

    // Reset with a pending load: quiescent outputs, defaults active, no ack/error.
    loadRun(1, 100);
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      stepClk();
      checkOutput($sformatf("reset hold %0d", i), 32'(outs()), 32'(5'b00001));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    firstOs = 0;
    sawCfg  = 1'b0;
    for (int i = 1; i <= 3000; i++) begin
      stepClk();
      if (cfg_ack || cfg_error) sawCfg = 1'b1;
      if (os_tick) begin
        firstOs = i;
        break;
      end
    end
    checkOutput("default first os_tick", 32'(firstOs), 32'(DEF_FIRST_OS));
    checkOutput("no ack/err after reset", 32'(sawCfg), 32'(0));

    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      stepClk();
      checkOutput($sformatf("disabled %0d", i), 32'(outs()), 32'(5'b00001));
    end

    // baud=3/freq=100: 12 oversample ticks per 100 cycles, spacing 8 or 9, no drift.
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 100);
    stepClk();
    checkOutput("b3 capture", 32'(outs()), 32'(5'b00001));
    applyStimulus(1'b0, 1'b0, 1'b0, 3, 100);
    stepClk();
    checkOutput("b3 ack", 32'(outs()), 32'(5'b10001));
    n = 0; base = 0; stepM = 12; freqM = 100;
    expAckAt = -1; expErrAt = -1; switchAt = -1;
    osCount = 0; bitCount = 0; lastOs = -1; minSp = 1000; maxSp = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    runTo(10000);
    checkOutput("b3 os count", 32'(osCount), 32'(1200));
    checkOutput("b3 bit count", 32'(bitCount), 32'(300));
    checkOutput("b3 min spacing", 32'(minSp), 32'(8));
    checkOutput("b3 max spacing", 32'(maxSp), 32'(9));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_baud_nco.md
# uart_baud_nco

Parametrised fractional baud-rate generator for the UART datapath. A phase accumulator produces exact-average oversample ticks (`os_tick`) and bit ticks (`bit_tick`), plus a 50%-duty `uartClock` with no division hardware. Baud rate and clock frequency are runtime-reconfigurable through a shadow register, applied only on a bit boundary. It sits between the system clock domain and the UART TX/RX engines, which consume the single-cycle ticks as clock enables.

## Interface
- `OVERSAMPLE`, 16 — oversample ticks per bit; power of two, ≥4.
- `BAUD_W`, 20 — width of the `BaudRate` input.
- `FREQ_W`, 30 — width of the `ClockFrequency` input.
- `DEFAULT_BAUD`, 9600 — active baud rate after reset.
- `DEFAULT_FREQ`, 100_000_000 — active clock frequency after reset.
- `clock` input 1 — system clock; all logic on the rising edge.
- `Reset` input 1 — synchronous, active-high.
- `enable` input 1 — run generator; low forces idle.
- `BaudRate` input BAUD_W — requested baud, sampled on `cfg_load`.
- `ClockFrequency` input FREQ_W — system clock in Hz, sampled on `cfg_load`.
- `cfg_load` input 1 — one-cycle strobe capturing a new configuration.
- `cfg_ack` output 1 — one-cycle pulse: pending configuration became active.
- `cfg_error` output 1 — one-cycle pulse: pending configuration rejected.
- `os_tick` output 1 — one-cycle oversample enable.
- `bit_tick` output 1 — one-cycle enable, once per bit (every OVERSAMPLE `os_tick`s).
- `uartClock` output 1 — square wave at the baud rate, high for the first half of each bit.

## Operation
- Active config: `baud_a`, `freq_a`. Step = `baud_a*OVERSAMPLE`, width BAUD_W+log2(OVERSAMPLE).
- Accumulator: FREQ_W+1 bits. Each enabled cycle, `sum = acc + step`:
  - if `sum >= freq_a`: `acc <= sum - freq_a`, `os_tick <= 1`;
  - otherwise `acc <= sum`.
- Phase counter `os_cnt`, log2(OVERSAMPLE) bits, advances on each accumulator overflow and wraps OVERSAMPLE-1→0.
  - `bit_tick <= 1` on the overflow that wraps `os_cnt`.
  - `uartClock <= (next os_cnt < OVERSAMPLE/2)`.
- Configuration is valid iff `baud != 0`, `freq != 0` and `2*baud*OVERSAMPLE <= freq`.
- `cfg_load` captures the inputs into pending registers and sets `pend`. A second load while `pend` is set overwrites them; the latest load wins.
- Apply point: the cycle `bit_tick` is asserted, or any cycle with `enable` low (or enabled but no prior tick since enable).
  - At the apply point, a valid pending config is copied to active, `acc` and `os_cnt` clear, and `cfg_ack` pulses.
  - An invalid pending config is dropped, `cfg_error` pulses, and the active config is unchanged.
  - `pend` clears in both cases.
- `cfg_load` in the same cycle as an apply point: the old pending config is applied; the new one becomes pending for the next apply point.
- With `enable` low: `acc = 0`, `os_cnt = 0`, `os_tick = bit_tick = 0`, `uartClock = 1`. The config path stays live.
- Reset: active config = defaults; `acc`, `os_cnt` and `pend` = 0; `os_tick`, `bit_tick`, `cfg_ack`, `cfg_error` = 0; `uartClock` = 1. Reset mid-operation discards any pending config without `cfg_ack` or `cfg_error`.

## Timing
- All outputs are registered.
- First `os_tick` is high after ceil(`freq_a`/step) enabled rising edges following enable or apply.
- Average `os_tick` rate is exactly `baud_a*OVERSAMPLE` per `freq_a` cycles. Spacing jitter is at most 1 cycle.
- `bit_tick` coincides with every OVERSAMPLE-th `os_tick` and with the rising edge of `uartClock`.
- Disabled: `cfg_ack`/`cfg_error` pulse 2 cycles after `cfg_load` (capture, then apply).
- `enable` deassert takes effect at the next edge. Re-enable restarts the phase from 0.

## Structure
- Package `uart_pkg`:
  - default baud and frequency constants;
  - width localparams;
  - function `baud_cfg_valid(baud, freq, os)`.
- Sub-module `frac_tick_nco`: accumulator plus overflow compare, with `step`/`modulus`/`clear`/`en` inputs and a `tick` output. The top level holds the phase counter, shadow registers and apply logic.

## Test plan
- Set `OVERSAMPLE=4`, load freq=100, baud=1, `enable=1` → `cfg_ack` pulses; then `os_tick` every 25 cycles, `bit_tick` every 100 cycles, and `uartClock` 50 cycles high / 50 low.
- freq=100, baud=3, OS=4 → `os_tick` spacings are 8 or 9 cycles; exactly 12 `os_tick`s and 3 `bit_tick`s per 100 cycles; no drift over 10,000 cycles.
- Running at baud=1, load baud=2 at cycle 40 of a bit → rate unchanged until the next `bit_tick`; `cfg_ack` coincides with it; the next bit is 50 cycles long.
- Load freq=100, baud=13, OS=4 (104 > 100) → `cfg_error` pulse; rate unchanged; `cfg_ack` stays 0.
- Two loads (baud=2, then baud=4) within one bit → a single `cfg_ack`; baud=4 becomes active.
- `Reset` asserted mid-bit with a pending load → all ticks 0, `uartClock=1`, defaults active, no ack/error; `enable` low holds `uartClock=1` with no ticks.
